// File: rtl/dm_pkg.sv
// dm_pkg: sequencer state encoding, command-master BTT limits and a chunk-size legality check
package dm_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACK, ST_WAIT_DONE, ST_FINISH} dm_state_e;
  localparam int DM_BTT_W = 23;
  localparam int DM_MAX_BTT = 2**23 - 1;
  localparam int DM_MAX_CHUNK = (DM_MAX_BTT + 1) / 2;
  function automatic bit chunk_ok(input int max_chunk);
    return max_chunk >= 1 && max_chunk <= DM_MAX_CHUNK && (max_chunk & (max_chunk - 1)) == 0;
  endfunction
endpackage

// File: rtl/dm_xfer_sequencer.sv
// dm_xfer_sequencer: splits one work request (s_wr_*) into <=MAX_CHUNK DataMover commands (dm_start/dm_* fields, paced by dm_ready), flagging busy, wr_done and wr_err
module dm_xfer_sequencer
  import dm_pkg::*;
#(
  parameter int MAX_CHUNK = 4096,
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_wr_valid,
  output logic             s_wr_ready,
  input  logic             s_wr_is_read,
  input  logic [31:0]      s_wr_saddr,
  input  logic [31:0]      s_wr_daddr,
  input  logic [LEN_W-1:0] s_wr_len,
  output logic             dm_start,
  output logic             dm_is_read,
  output logic [31:0]      dm_saddr,
  output logic [31:0]      dm_daddr,
  output logic [31:0]      dm_btt,
  input  logic             dm_ready,
  output logic             busy,
  output logic             wr_done,
  output logic             wr_err
);
  localparam bit CHUNK_OK = chunk_ok(MAX_CHUNK);
  if (!CHUNK_OK) begin : g_bad_chunk
    $error("MAX_CHUNK must be a power of two in 1..2^22");
  end
  dm_state_e state;
  logic is_read_q;
  logic [31:0] cur_saddr, cur_daddr;
  logic [LEN_W-1:0] remaining, btt_len;
  function automatic logic [DM_BTT_W-1:0] chunk_of(input logic [LEN_W-1:0] rem);
    return rem < LEN_W'(MAX_CHUNK) ? DM_BTT_W'(rem) : DM_BTT_W'(MAX_CHUNK);
  endfunction
  assign s_wr_ready = state == ST_IDLE;
  assign btt_len = LEN_W'(dm_btt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      dm_start <= 1'b0;
      busy <= 1'b0;
      wr_done <= 1'b0;
      wr_err <= 1'b0;
      dm_is_read <= 1'b1;
      dm_saddr <= '0;
      dm_daddr <= '0;
      dm_btt <= '0;
      is_read_q <= 1'b1;
      cur_saddr <= '0;
      cur_daddr <= '0;
      remaining <= '0;
    end else begin
      dm_start <= 1'b0;
      wr_done <= 1'b0;
      wr_err <= 1'b0;
      unique case (state)
        ST_IDLE: if (s_wr_valid) begin
          is_read_q <= s_wr_is_read;
          cur_saddr <= s_wr_saddr;
          cur_daddr <= s_wr_daddr;
          remaining <= s_wr_len;
          busy <= 1'b1;
          state <= s_wr_len == '0 ? ST_FINISH : ST_ISSUE;
          wr_done <= s_wr_len == '0;
          wr_err <= s_wr_len == '0;
        end
        ST_ISSUE: begin
          dm_btt <= 32'(chunk_of(remaining));
          dm_saddr <= cur_saddr;
          dm_daddr <= cur_daddr;
          dm_is_read <= is_read_q;
          dm_start <= dm_ready;
          state <= dm_ready ? ST_WAIT_ACK : ST_ISSUE;
        end
        ST_WAIT_ACK: state <= dm_ready ? ST_WAIT_ACK : ST_WAIT_DONE;
        ST_WAIT_DONE: if (dm_ready) begin
          cur_saddr <= cur_saddr + dm_btt;
          cur_daddr <= cur_daddr + dm_btt;
          remaining <= remaining - btt_len;
          wr_done <= remaining == btt_len;
          state <= remaining == btt_len ? ST_FINISH : ST_ISSUE;
        end
        ST_FINISH: begin
          busy <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_dm_xfer_sequencer.sv
// tb_dm_xfer_sequencer: randomized self-checking bench with a command-master model and a chunk-list scoreboard
module tb_dm_xfer_sequencer;
  localparam int MAXC = 4096;
  typedef struct {bit rd; bit [31:0] sa; bit [31:0] da; bit [31:0] btt;} cmd_t;
  logic clk = 0, rst_n = 0;
  logic s_wr_valid = 0, s_wr_is_read = 0;
  logic [31:0] s_wr_saddr = 0, s_wr_daddr = 0, s_wr_len = 0;
  logic s_wr_ready, dm_start, dm_is_read, busy, wr_done, wr_err;
  logic [31:0] dm_saddr, dm_daddr, dm_btt;
  logic dm_ready = 1;
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, force_low = 0;
  cmd_t exp_cmds[$], obs[$], cap, e;
  bit exp_err[$];
  bit prev_start = 0, inflight = 0, saw_low = 0, first_pending = 0, acc_hi = 0, ee;
  int acc_cyc = 0, rise_cyc = 0;

  dm_xfer_sequencer #(.MAX_CHUNK(MAXC), .LEN_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready), .s_wr_is_read(s_wr_is_read),
    .s_wr_saddr(s_wr_saddr), .s_wr_daddr(s_wr_daddr), .s_wr_len(s_wr_len),
    .dm_start(dm_start), .dm_is_read(dm_is_read), .dm_saddr(dm_saddr), .dm_daddr(dm_daddr),
    .dm_btt(dm_btt), .dm_ready(dm_ready), .busy(busy), .wr_done(wr_done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // command master: idles with ready high, drops ready the cycle after a start, stays busy a random while
  initial begin : cmd_master
    int ph, cnt;
    ph = 0;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin ph = 0; dm_ready = 1; end
      else if (ph == 0) begin
        if (dm_start) ph = 1;
        else if (force_low > 0) begin force_low--; dm_ready = 0; end
        else dm_ready = 1;
      end else if (ph == 1) begin
        dm_ready = 0;
        cnt = $urandom_range(1, 6);
        ph = 2;
      end else if (--cnt == 0) begin
        dm_ready = 1;
        ph = 0;
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("ready_vs_busy", s_wr_ready, !busy);
    chk("btt_high_bits", dm_btt[31:23], 0);
    if (s_wr_valid && s_wr_ready) begin acc_cyc = cyc; first_pending = 1; acc_hi = dm_ready; end
    if (dm_start) chk("start_width", prev_start, 0);
    if (dm_start && !prev_start) begin
      if (exp_cmds.size() == 0) chk("unexpected_start", 1, 0);
      else begin
        e = exp_cmds.pop_front();
        chk("cmd_btt", dm_btt, e.btt);
        chk("cmd_saddr", dm_saddr, e.sa);
        chk("cmd_daddr", dm_daddr, e.da);
        chk("cmd_dir", dm_is_read, e.rd);
      end
      if (first_pending && acc_hi) chk("accept_to_start", cyc - acc_cyc, 2);
      else if (!first_pending) chk("done_to_start", cyc - rise_cyc, 2);
      first_pending = 0;
      cap = '{dm_is_read, dm_saddr, dm_daddr, dm_btt};
      obs.push_back(cap);
      inflight = 1;
      saw_low = 0;
    end else if (inflight) begin
      chk("hold_addr", {dm_saddr, dm_daddr}, {cap.sa, cap.da});
      chk("hold_btt_dir", {dm_is_read, dm_btt}, {cap.rd, cap.btt});
      if (!dm_ready) saw_low = 1;
      else if (saw_low) begin rise_cyc = cyc; inflight = 0; end
    end
    if (wr_done) begin
      if (exp_err.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        ee = exp_err.pop_front();
        chk("done_err", wr_err, ee);
        chk("cmds_left", exp_cmds.size(), 0);
        if (ee) chk("zero_len_done_lat", cyc - acc_cyc, 1);
        else chk("ready_to_done", cyc - rise_cyc, 1);
      end
      done_cnt++;
    end else chk("err_without_done", wr_err, 0);
    prev_start = dm_start;
  end

  task automatic expect_req(input bit rd, input bit [31:0] sa, input bit [31:0] da, input bit [31:0] len);
    for (longint off = 0; off < len; off += MAXC) begin
      longint c;
      c = (len - off < MAXC) ? len - off : MAXC;
      exp_cmds.push_back('{rd, sa + 32'(off), da + 32'(off), 32'(c)});
    end
    exp_err.push_back(len == 0);
  endtask

  task automatic send(input bit rd, input bit [31:0] sa, input bit [31:0] da, input bit [31:0] len);
    int n;
    @(posedge clk); #1;
    s_wr_valid = 1; s_wr_is_read = rd; s_wr_saddr = sa; s_wr_daddr = da; s_wr_len = len;
    for (n = 0; n < 200 && !s_wr_ready; n++) begin @(posedge clk); #1; end
    chk("accept_timeout", s_wr_ready, 1);
    @(posedge clk); #1;
    s_wr_valid = 0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
    chk("done_timeout", done_cnt > d0, 1);
    repeat (4) @(posedge clk);
    chk("done_once", done_cnt, d0 + 1);
  endtask

  task automatic xfer(input bit rd, input bit [31:0] sa, input bit [31:0] da, input bit [31:0] len);
    int d0;
    d0 = done_cnt;
    expect_req(rd, sa, da, len);
    send(rd, sa, da, len);
    wait_done(d0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n, starts;
    bit [31:0] len, sa;
    #22;
    chk("rst_ready", s_wr_ready, 1);
    chk("rst_busy_done_err_start", {busy, wr_done, wr_err, dm_start}, 0);
    chk("rst_dir", dm_is_read, 1);
    chk("rst_fields", {dm_saddr, dm_daddr}, 0);
    chk("rst_btt", dm_btt, 0);
    @(posedge clk); #3 rst_n = 1;

    obs.delete();
    xfer(1, 32'h1000_0000, 32'h2000_0000, 10000);
    chk("t1_count", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("t1_btt0", obs[0].btt, 4096);
      chk("t1_btt1", obs[1].btt, 4096);
      chk("t1_btt2", obs[2].btt, 1808);
      chk("t1_sa0", obs[0].sa, 32'h1000_0000);
      chk("t1_sa1", obs[1].sa, 32'h1000_1000);
      chk("t1_sa2", obs[2].sa, 32'h1000_2000);
    end

    obs.delete();
    xfer(0, 32'h1000_0000, 32'h2000_0000, 4096);
    chk("t2_count", obs.size(), 1);
    if (obs.size() == 1) chk("t2_fields", {obs[0].rd, obs[0].da, obs[0].btt}, {1'b0, 32'h2000_0000, 32'd4096});

    obs.delete();
    d0 = done_cnt;
    expect_req(1, 32'h40, 32'h80, 0);
    send(1, 32'h40, 32'h80, 0);
    chk("t3_done_err", {wr_done, wr_err, dm_start}, 3'b110);
    @(posedge clk); #1;
    chk("t3_ready_back", {s_wr_ready, wr_done}, 2'b10);
    wait_done(d0);
    chk("t3_no_start", obs.size(), 0);

    obs.delete();
    force_low = 22;
    d0 = done_cnt;
    expect_req(0, 32'h5000_0000, 32'h6000_0000, 3000);
    send(0, 32'h5000_0000, 32'h6000_0000, 3000);
    starts = 0;
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; starts += dm_start; end
    chk("t4_no_start_while_low", starts, 0);
    wait_done(d0);
    chk("t4_count", obs.size(), 1);

    obs.delete();
    xfer(1, 32'hFFFF_F000, 32'h3000_0000, 8192);
    chk("t5_count", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("t5_sa0", obs[0].sa, 32'hFFFF_F000);
      chk("t5_wrap", {obs[1].sa, obs[1].btt}, {32'h0, 32'd4096});
    end

    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 4);
      len = n == 0 ? $urandom_range(1, 300) : n == 1 ? 4096 * $urandom_range(1, 3) :
            n == 2 ? $urandom_range(4097, 14000) : n == 3 ? 0 : $urandom_range(1, 20000);
      sa = ($urandom_range(0, 3) == 0) ? 32'hFFFF_F000 + $urandom_range(0, 4095) : $urandom;
      xfer(1'($urandom_range(0, 1)), sa, $urandom, len);
    end

    obs.delete();
    expect_req(1, 32'h7000_0000, 32'h7100_0000, 3 * 4096);
    send(1, 32'h7000_0000, 32'h7100_0000, 3 * 4096);
    for (n = 0; n < 500 && obs.size() < 2; n++) @(posedge clk);
    chk("t6_second_start", obs.size() >= 2, 1);
    for (n = 0; n < 50 && dm_ready; n++) begin @(posedge clk); #1; end
    chk("t6_in_wait_done", dm_ready, 0);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("t6_async_reset", {dm_start, busy, wr_done}, 0);
    exp_cmds.delete();
    exp_err.delete();
    inflight = 0;
    prev_start = 0;
    first_pending = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    obs.delete();
    xfer(1, 32'h100, 32'h200, 100);
    chk("t6_after_reset", obs.size(), 1);
    if (obs.size() == 1) chk("t6_btt", obs[0].btt, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dm_xfer_sequencer.md
Name: dm_xfer_sequencer

Overview:
- Sits directly upstream of the DataMover command master. It accepts one transfer work request (direction, source address, destination address, total length) over a valid/ready handshake.
- It splits the request into chunks of at most MAX_CHUNK bytes. For each chunk it drives the command master's start/saddr/daddr/btt/is_read inputs, waits for the chunk to finish, then advances the addresses.
- A done pulse is raised when the last chunk completes, so software-sized transfers never exceed the command master's 23-bit BTT field.

Parameters:
- MAX_CHUNK, 4096: maximum bytes per issued command. Power of two, 1 to 2^22.
- LEN_W, 32: width of the total-length field and the remaining-bytes counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_wr_valid  in  1  work request valid
- s_wr_ready  out  1  work request accepted when valid&ready; high only in IDLE
- s_wr_is_read  in  1  1 = MM2S (read memory), 0 = S2MM (write memory)
- s_wr_saddr  in  32  source byte address
- s_wr_daddr  in  32  destination byte address
- s_wr_len  in  LEN_W  total bytes
- dm_start  out  1  one-cycle start pulse to the command master
- dm_is_read  out  1  direction of the current chunk
- dm_saddr  out  32  current chunk source address
- dm_daddr  out  32  current chunk destination address
- dm_btt  out  32  current chunk byte count; bits [31:23] are always 0
- dm_ready  in  1  command master idle (high only while it is in IDLE)
- busy  out  1  high from acceptance until the done pulse inclusive
- wr_done  out  1  one-cycle pulse when the whole request is finished
- wr_err  out  1  one-cycle pulse coincident with wr_done on a zero-length request

Behaviour:
- Reset: asynchronous, active-low; affects all state and outputs.
  - Reset values: state IDLE, dm_start 0, busy 0, wr_done 0, wr_err 0, dm_is_read 1, dm_saddr/dm_daddr/dm_btt 0, internal counters 0.
  - s_wr_ready is 1 after reset (combinational from state==IDLE).
  - Reset mid-operation abandons the request immediately. No further dm_start is issued. The command master is reset by the same rst_n.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, FINISH.
- IDLE:
  - On s_wr_valid, register is_read, saddr, daddr and len into cur_saddr, cur_daddr and remaining.
  - If len==0, go to FINISH with err flagged. Otherwise go to ISSUE.
  - busy goes high on the next edge.
- ISSUE:
  - chunk = min(remaining, MAX_CHUNK).
  - dm_btt, dm_saddr, dm_daddr and dm_is_read are registered from chunk, cur_saddr, cur_daddr and the stored direction.
  - If dm_ready==1, dm_start is set to 1 on the next edge and the FSM moves to WAIT_ACK.
  - If dm_ready==0, the FSM stays in ISSUE with no start.
- WAIT_ACK:
  - dm_start returns to 0 on the next edge, so it is exactly one cycle wide and the command master's rising-edge detector sees one edge.
  - Wait for dm_ready==0, which is expected 2 cycles after entry, then go to WAIT_DONE.
- WAIT_DONE:
  - Wait for dm_ready==1.
  - On that edge: cur_saddr += dm_btt, cur_daddr += dm_btt, remaining -= dm_btt.
  - If the new remaining is 0, go to FINISH; otherwise go to ISSUE.
- FINISH:
  - Pulse wr_done for 1 cycle, and wr_err if the request was zero-length.
  - busy drops, then return to IDLE. s_wr_ready rises in the following cycle.
- Command field stability: dm_saddr, dm_daddr, dm_btt and dm_is_read are held constant from the cycle dm_start rises until WAIT_DONE exits. The command master builds TDATA combinationally from them.
- Address arithmetic: 32-bit modulo 2^32, so wrap past 0xFFFF_FFFF is silent. Both addresses advance every chunk, independent of direction.
- Latency:
  - Acceptance to first dm_start: 2 cycles if dm_ready is already high.
  - Chunk-complete (dm_ready rising) to next dm_start: 2 cycles.
- Back-pressure: new requests are not accepted while busy. Request inputs are ignored outside IDLE.

Decomposition:
- Shared package dm_pkg holds:
  - the state enum;
  - DM_BTT_W=23;
  - DM_MAX_BTT = 2^23-1;
  - a compile-time check constant asserting MAX_CHUNK <= 2^22.
- No sub-module is needed. The min() chunk calculation is a local function.

Test Plan:
1. len=10000, saddr=0x1000_0000, daddr=0x2000_0000, read, MAX_CHUNK=4096, cmd-master model -> three dm_start pulses.
   - btt = 4096, 4096, 1808.
   - saddr = 0x1000_0000, 0x1000_1000, 0x1000_2000.
   - exactly one wr_done; wr_err=0.
2. len=4096, write -> one dm_start with btt=4096, dm_is_read=0, daddr=0x2000_0000; wr_done 1 cycle after dm_ready returns high.
3. len=0 -> no dm_start; wr_done and wr_err both pulse 1 cycle after acceptance; s_wr_ready high 2 cycles after acceptance.
4. dm_ready held low for 20 cycles when ISSUE is entered -> no dm_start until dm_ready rises; then exactly one 1-cycle pulse; fields stable until completion.
5. saddr=0xFFFF_F000, len=8192 -> second chunk dm_saddr=0x0000_0000, btt=4096; no error.
6. rst_n asserted in WAIT_DONE of chunk 2 -> dm_start=0, busy=0, wr_done=0 asynchronously; after release a new len=100 request completes with btt=100.
